// File: rtl/bus_cmd_master.sv
// Byte-stream command master: decodes UART write/read packets into single
// 16-bit register-bus strobes and returns read status/data bytes to the UART.
module bus_cmd_master #(
  parameter int ADDR_WIDTH   = 8,
  parameter int RD_TIMEOUT   = 16,
  parameter int BYTE_TIMEOUT = 100000
) (
  input  logic                  i_Bus_Clk,
  input  logic                  i_Bus_Rst_L,
  input  logic                  i_Rx_DV,
  input  logic [7:0]            i_Rx_Byte,
  output logic                  o_Tx_DV,
  output logic [7:0]            o_Tx_Byte,
  input  logic                  i_Tx_Done,
  output logic                  o_Bus_CS,
  output logic                  o_Bus_Wr_Rd_n,
  output logic [ADDR_WIDTH-1:0] o_Bus_Addr8,
  output logic [15:0]           o_Bus_Wr_Data,
  input  logic [15:0]           i_Bus_Rd_Data,
  input  logic                  i_Bus_Rd_DV,
  output logic                  o_Busy
);

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_ADDR    = 4'd1;
  localparam logic [3:0] ST_WDH     = 4'd2;
  localparam logic [3:0] ST_WDL     = 4'd3;
  localparam logic [3:0] ST_WR      = 4'd4;
  localparam logic [3:0] ST_RD      = 4'd5;
  localparam logic [3:0] ST_RD_WAIT = 4'd6;
  localparam logic [3:0] ST_TX_SEND = 4'd7;
  localparam logic [3:0] ST_TX_WAIT = 4'd8;

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;

  // One timer serves both the inter-byte and the read-data timeouts.
  localparam int TMAX = (BYTE_TIMEOUT > RD_TIMEOUT) ? BYTE_TIMEOUT : RD_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] BYTE_LAST = TW'(BYTE_TIMEOUT - 1);
  localparam logic [TW-1:0] RD_LAST   = TW'(RD_TIMEOUT - 1);

  logic [3:0]            state_r, state_s;
  logic                  is_write_r, is_write_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [7:0]            data_hi_r, data_hi_s;
  logic [TW-1:0]         timer_r, timer_s;
  logic [15:0]           rd_data_r, rd_data_s;
  logic [1:0]            idx_r, idx_s;
  logic                  cs_r, cs_s;
  logic                  wr_rd_n_r, wr_rd_n_s;
  logic [ADDR_WIDTH-1:0] bus_addr_r, bus_addr_s;
  logic [15:0]           bus_wdata_r, bus_wdata_s;
  logic                  tx_dv_r, tx_dv_s;
  logic [7:0]            tx_byte_r, tx_byte_s;
  logic                  busy_r, busy_s;

  // Next-state and next-output decode; outputs are registered from these.
  always_comb begin
    state_s     = state_r;
    is_write_s  = is_write_r;
    addr_s      = addr_r;
    data_hi_s   = data_hi_r;
    timer_s     = timer_r;
    rd_data_s   = rd_data_r;
    idx_s       = idx_r;
    cs_s        = 1'b0;
    wr_rd_n_s   = wr_rd_n_r;
    bus_addr_s  = bus_addr_r;
    bus_wdata_s = bus_wdata_r;
    tx_dv_s     = 1'b0;
    tx_byte_s   = tx_byte_r;
    case (state_r)
      ST_IDLE: begin
        if (i_Rx_DV && ((i_Rx_Byte == CMD_WR) || (i_Rx_Byte == CMD_RD))) begin
          is_write_s = (i_Rx_Byte == CMD_WR);
          timer_s    = '0;
          state_s    = ST_ADDR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (i_Rx_DV) begin
          addr_s  = ADDR_WIDTH'(i_Rx_Byte);
          timer_s = '0;
          if (is_write_r) begin
            state_s = ST_WDH;
          end else begin
            state_s    = ST_RD;
            cs_s       = 1'b1;
            wr_rd_n_s  = 1'b0;
            bus_addr_s = ADDR_WIDTH'(i_Rx_Byte);
          end
        end else if (timer_r == BYTE_LAST) begin
          state_s = ST_IDLE;
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end
      ST_WDH: begin
        if (i_Rx_DV) begin
          data_hi_s = i_Rx_Byte;
          timer_s   = '0;
          state_s   = ST_WDL;
        end else if (timer_r == BYTE_LAST) begin
          state_s = ST_IDLE;
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end
      ST_WDL: begin
        if (i_Rx_DV) begin
          timer_s     = '0;
          state_s     = ST_WR;
          cs_s        = 1'b1;
          wr_rd_n_s   = 1'b1;
          bus_addr_s  = addr_r;
          bus_wdata_s = {data_hi_r, i_Rx_Byte};
        end else if (timer_r == BYTE_LAST) begin
          state_s = ST_IDLE;
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end
      ST_WR: begin
        state_s = ST_IDLE;
      end
      ST_RD: begin
        timer_s = '0;
        state_s = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // Returned data takes priority over a timeout in the same clock.
        if (i_Bus_Rd_DV) begin
          rd_data_s = i_Bus_Rd_Data;
          idx_s     = 2'd0;
          tx_dv_s   = 1'b1;
          tx_byte_s = 8'h00;
          state_s   = ST_TX_SEND;
        end else if (timer_r == RD_LAST) begin
          rd_data_s = 16'h0000;
          idx_s     = 2'd0;
          tx_dv_s   = 1'b1;
          tx_byte_s = 8'h01;
          state_s   = ST_TX_SEND;
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end
      ST_TX_SEND: begin
        state_s = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        if (!i_Tx_Done) begin
          state_s = ST_TX_WAIT;
        end else if (idx_r == 2'd2) begin
          state_s = ST_IDLE;
        end else begin
          idx_s     = idx_r + 2'd1;
          tx_dv_s   = 1'b1;
          tx_byte_s = (idx_r == 2'd0) ? rd_data_r[15:8] : rd_data_r[7:0];
          state_s   = ST_TX_SEND;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and registered-output update.
  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      state_r     <= ST_IDLE;
      is_write_r  <= 1'b0;
      addr_r      <= '0;
      data_hi_r   <= 8'h00;
      timer_r     <= '0;
      rd_data_r   <= 16'h0000;
      idx_r       <= 2'd0;
      cs_r        <= 1'b0;
      wr_rd_n_r   <= 1'b0;
      bus_addr_r  <= '0;
      bus_wdata_r <= 16'h0000;
      tx_dv_r     <= 1'b0;
      tx_byte_r   <= 8'h00;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      is_write_r  <= is_write_s;
      addr_r      <= addr_s;
      data_hi_r   <= data_hi_s;
      timer_r     <= timer_s;
      rd_data_r   <= rd_data_s;
      idx_r       <= idx_s;
      cs_r        <= cs_s;
      wr_rd_n_r   <= wr_rd_n_s;
      bus_addr_r  <= bus_addr_s;
      bus_wdata_r <= bus_wdata_s;
      tx_dv_r     <= tx_dv_s;
      tx_byte_r   <= tx_byte_s;
      busy_r      <= busy_s;
    end
  end

  assign o_Tx_DV       = tx_dv_r;
  assign o_Tx_Byte     = tx_byte_r;
  assign o_Bus_CS      = cs_r;
  assign o_Bus_Wr_Rd_n = wr_rd_n_r;
  assign o_Bus_Addr8   = bus_addr_r;
  assign o_Bus_Wr_Data = bus_wdata_r;
  assign o_Busy        = busy_r;

endmodule

// File: tb/tb_bus_cmd_master.sv
// Directed bench for bus_cmd_master: packet vectors with hand-computed bus
// strobes, response bytes and cycle distances.
module tb_bus_cmd_master;

  logic        clk;
  logic        rst_n;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_done;
  logic        cs;
  logic        wr_rd_n;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rd_data;
  logic        rd_dv;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int cs_cnt = 0;
  int cs_cyc = 0;
  int tx_cnt = 0;
  int rd_mode = 0;
  logic rd_pend = 1'b0;
  logic [7:0] tx_q[$];
  int tx_cyc_q[$];
  int cs_before;

  bus_cmd_master #(.ADDR_WIDTH(8), .RD_TIMEOUT(16), .BYTE_TIMEOUT(40)) dut (
    .i_Bus_Clk(clk), .i_Bus_Rst_L(rst_n), .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
    .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte), .i_Tx_Done(tx_done),
    .o_Bus_CS(cs), .o_Bus_Wr_Rd_n(wr_rd_n), .o_Bus_Addr8(addr),
    .o_Bus_Wr_Data(wdata), .i_Bus_Rd_Data(rd_data), .i_Bus_Rd_DV(rd_dv),
    .o_Busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: sampled 1ns after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (cs) begin
      cs_cnt++;
      cs_cyc = cyc;
    end
    if (tx_dv) begin
      tx_q.push_back(tx_byte);
      tx_cyc_q.push_back(cyc);
    end
  end

  // Bus slave: answers a read one clock after the strobe unless muted.
  always @(posedge clk) begin
    #1;
    rd_dv   = rd_pend;
    rd_data = rd_pend ? 16'h1234 : 16'hDEAD;
    rd_pend = cs && !wr_rd_n && (rd_mode == 0) && rst_n;
  end

  // UART transmitter: Tx_Done three clocks after each Tx_DV.
  always @(posedge clk) begin
    #1;
    tx_done = 1'b0;
    if (!rst_n) begin
      tx_cnt = 0;
    end else if (tx_dv) begin
      tx_cnt = 3;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_done = 1'b1;
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_tx(input string tag, input int n);
    int k = 0;
    while (tx_q.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk_eq(tag, tx_q.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk_eq(tag, busy, 1'b0);
  endtask

  task automatic chk_resp(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input int first_lat);
    if (tx_q.size() >= 3) begin
      chk_eq({tag, "_b0"}, tx_q[0], b0);
      chk_eq({tag, "_b1"}, tx_q[1], b1);
      chk_eq({tag, "_b2"}, tx_q[2], b2);
      chk_eq({tag, "_lat"}, tx_cyc_q[0] - cs_cyc, first_lat);
      chk_eq({tag, "_gap1"}, tx_cyc_q[1] - tx_cyc_q[0], 4);
      chk_eq({tag, "_gap2"}, tx_cyc_q[2] - tx_cyc_q[1], 4);
    end else begin
      chk_eq({tag, "_count"}, tx_q.size(), 3);
    end
  endtask

  initial begin
    rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; tx_done = 1'b0;
    rd_dv = 1'b0; rd_data = 16'h0000;
    repeat (3) @(negedge clk);
    #1;
    chk_eq("rst_busy", busy, 1'b0);
    chk_eq("rst_cs", cs, 1'b0);
    chk_eq("rst_txdv", tx_dv, 1'b0);
    chk_eq("rst_wdata", wdata, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Write followed immediately by a read (back-to-back command byte)
    send(8'h57, 1); send(8'h04, 1); send(8'hBE, 1); send(8'hEF, 0);
    #1;
    chk_eq("wr_cs", cs, 1'b1);
    chk_eq("wr_dir", wr_rd_n, 1'b1);
    chk_eq("wr_addr", addr, 8'h04);
    chk_eq("wr_data", wdata, 16'hBEEF);
    chk_eq("wr_busy_cs", busy, 1'b1);
    @(negedge clk);
    chk_eq("wr_busy_after", busy, 1'b0);
    chk_eq("wr_cs_once", cs, 1'b0);
    chk_eq("wr_no_tx", tx_q.size(), 0);
    send(8'h52, 0);
    send(8'h02, 0);
    #1;
    chk_eq("rd_cs", cs, 1'b1);
    chk_eq("rd_dir", wr_rd_n, 1'b0);
    chk_eq("rd_addr", addr, 8'h02);
    chk_eq("rd_wdata_hold", wdata, 16'hBEEF);
    wait_tx("rd_wait", 3);
    chk_resp("rd", 8'h00, 8'h12, 8'h34, 2);
    wait_idle("rd_idle");
    chk_eq("rd_cs_total", cs_cnt, 2);

    // Read timeout
    tx_q.delete(); tx_cyc_q.delete();
    rd_mode = 1;
    @(negedge clk);
    send(8'h52, 1); send(8'h07, 0);
    wait_tx("to_wait", 3);
    chk_resp("to", 8'h01, 8'h00, 8'h00, 17);
    wait_idle("to_idle");
    rd_mode = 0;

    // Junk byte, then a write abandoned by the byte timeout
    cs_before = cs_cnt;
    @(negedge clk);
    send(8'hAA, 1); send(8'h57, 1); send(8'h06, 1); send(8'h00, 60);
    chk_eq("bto_no_cs", cs_cnt, cs_before);
    chk_eq("bto_idle", busy, 1'b0);
    send(8'h57, 1); send(8'h06, 1); send(8'hCA, 30); send(8'hFE, 0);
    #1;
    chk_eq("bto_wr_cs", cs, 1'b1);
    chk_eq("bto_wr_addr", addr, 8'h06);
    chk_eq("bto_wr_data", wdata, 16'hCAFE);
    chk_eq("bto_cs_total", cs_cnt, cs_before + 1);

    // Bytes arriving during a read response are dropped
    tx_q.delete(); tx_cyc_q.delete();
    cs_before = cs_cnt;
    @(negedge clk);
    send(8'h52, 1); send(8'h02, 0);
    wait_tx("drop_first", 1);
    send(8'h57, 0); send(8'h04, 0);
    wait_tx("drop_wait", 3);
    chk_resp("drop", 8'h00, 8'h12, 8'h34, 2);
    wait_idle("drop_idle");
    repeat (5) @(negedge clk);
    chk_eq("drop_still_idle", busy, 1'b0);
    chk_eq("drop_cs_total", cs_cnt, cs_before + 1);

    // Reset in the middle of a response
    tx_q.delete(); tx_cyc_q.delete();
    @(negedge clk);
    send(8'h52, 1); send(8'h00, 0);
    wait_tx("rst_mid_wait", 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_eq("rstm_busy", busy, 1'b0);
    chk_eq("rstm_txbyte", tx_byte, 8'h00);
    chk_eq("rstm_txdv", tx_dv, 1'b0);
    chk_eq("rstm_cs", cs, 1'b0);
    chk_eq("rstm_dir", wr_rd_n, 1'b0);
    chk_eq("rstm_addr", addr, 8'h00);
    chk_eq("rstm_wdata", wdata, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tx_q.delete(); tx_cyc_q.delete();
    repeat (20) @(negedge clk);
    chk_eq("rstm_no_tx", tx_q.size(), 0);
    chk_eq("rstm_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_cmd_master.md
# bus_cmd_master

Byte-stream command master that turns host packets (from the UART receiver) into single 16-bit register-bus transactions and returns read results to the UART transmitter. It sits directly upstream of the bus register slaves: it drives chip-select, write/read-not, byte address and write data, and consumes the slave's read data and read-data-valid.

## Interface
Parameters:
- ADDR_WIDTH, 8, width of o_Bus_Addr8; the address byte is truncated to its low ADDR_WIDTH bits.
- RD_TIMEOUT, 16, clocks to wait for i_Bus_Rd_DV after a read strobe.
- BYTE_TIMEOUT, 100000, maximum clocks between consecutive packet bytes.

Ports:
- i_Bus_Clk  in  1  clock, all logic on rising edge.
- i_Bus_Rst_L  in  1  asynchronous, active-low reset.
- i_Rx_DV  in  1  one-clock pulse, i_Rx_Byte valid.
- i_Rx_Byte  in  8  received byte.
- o_Tx_DV  out  1  one-clock pulse requesting transmission of o_Tx_Byte.
- o_Tx_Byte  out  8  byte to transmit; held until next o_Tx_DV.
- i_Tx_Done  in  1  one-clock pulse, transmitter finished current byte.
- o_Bus_CS  out  1  one-clock transaction strobe.
- o_Bus_Wr_Rd_n  out  1  1 = write, 0 = read; valid with o_Bus_CS.
- o_Bus_Addr8  out  ADDR_WIDTH  byte address; valid with o_Bus_CS.
- o_Bus_Wr_Data  out  16  write data; valid with o_Bus_CS.
- i_Bus_Rd_Data  in  16  read data, valid when i_Bus_Rd_DV.
- i_Bus_Rd_DV  in  1  read data valid pulse.
- o_Busy  out  1  high in every state except IDLE.

## Operation
- Packets: write = 0x57, addr, data_hi, data_lo. Read = 0x52, addr. Response to read only: status, data_hi, data_lo; status 0x00 = ok, 0x01 = timeout (data 0x0000). Writes get no response.
- States: IDLE, ADDR, WDH, WDL, WR, RD, RD_WAIT, TX_SEND, TX_WAIT.
- IDLE: on i_Rx_DV, 0x57 or 0x52 latches the command -> ADDR; any other byte ignored, stay IDLE.
- ADDR: byte latched into address; write -> WDH, read -> RD. WDH latches data[15:8] -> WDL; WDL latches data[7:0] -> WR.
- WR: o_Bus_CS=1, o_Bus_Wr_Rd_n=1 for one clock -> IDLE.
- RD: o_Bus_CS=1, o_Bus_Wr_Rd_n=0 for one clock, clears timeout counter -> RD_WAIT.
- RD_WAIT: i_Bus_Rd_DV latches i_Bus_Rd_Data, status 0x00 -> TX_SEND; if counter reaches RD_TIMEOUT first, status 0x01, data 0x0000 -> TX_SEND. Counter increments each RD_WAIT clock.
- TX_SEND: o_Tx_DV=1 one clock with byte index 0/1/2 (status, hi, lo) -> TX_WAIT. TX_WAIT: on i_Tx_Done, index 2 -> IDLE, else index+1 -> TX_SEND.
- Byte timeout: in ADDR/WDH/WDL a counter clears on each i_Rx_DV; reaching BYTE_TIMEOUT discards the packet -> IDLE, no bus strobe.
- i_Rx_DV in WR/RD/RD_WAIT/TX_SEND/TX_WAIT is dropped (no queueing).
- i_Bus_Rd_DV outside RD_WAIT ignored. i_Bus_Rd_DV and timeout in same cycle: data wins (status 0x00).
- o_Bus_Addr8/o_Bus_Wr_Data hold last value between strobes.
- Reset (any time, incl. mid-packet or mid-response): state IDLE, all counters 0, every output 0; a partly sent response is abandoned.

## Timing
- Write: o_Bus_CS high the clock after the data_lo i_Rx_DV is sampled (1-cycle latency); o_Busy low the following clock.
- Read: o_Bus_CS high the clock after the addr i_Rx_DV is sampled; first o_Tx_DV the clock after i_Bus_Rd_DV is sampled.
- Timeout: with i_Bus_Rd_DV never asserted, first o_Tx_DV occurs RD_TIMEOUT+1 clocks after the o_Bus_CS clock.
- Next o_Tx_DV exactly one clock after each i_Tx_Done; i_Tx_Done in the same clock as o_Tx_DV is ignored.
- Back-to-back packets: a command byte arriving the clock after returning to IDLE is accepted.

## Test plan
- Write 0x57,0x04,0xBE,0xEF -> single o_Bus_CS with Wr_Rd_n=1, Addr8=0x04, Wr_Data=0xBEEF; no o_Tx_DV.
- Read 0x52,0x02 with slave returning 0x1234 one clock after CS -> Tx bytes 0x00,0x12,0x34, each after i_Tx_Done.
- Read with i_Bus_Rd_DV never asserted, RD_TIMEOUT=16 -> Tx 0x01,0x00,0x00; first o_Tx_DV 17 clocks after CS.
- Bytes 0xAA then 0x57,0x06,0x00 then silence > BYTE_TIMEOUT -> no o_Bus_CS; subsequent full write to 0x06 succeeds.
- Bytes sent during read response -> ignored; response completes intact; o_Busy low after last i_Tx_Done.
- Reset asserted after 0x52,0x00 during TX_WAIT -> all outputs 0 immediately; no further o_Tx_DV after release.
